// File: rtl/nes_mem_pkg.sv
// Shared types and constants for the cartridge memory arbiter.
package nes_mem_pkg;

  localparam int unsigned MEM_AW       = 22;
  localparam logic [7:0]  MEM_ERR_DATA = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_PPU = 1'b1
  } owner_t;

endpackage

// File: rtl/nes_mem_arbiter_if.sv
// CPU/PPU request ports and the shared memory-controller port of the arbiter.
interface nes_mem_arbiter_if;
  import nes_mem_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [MEM_AW-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_ack;

  logic              ppu_req;
  logic              ppu_we;
  logic [MEM_AW-1:0] ppu_addr;
  logic [7:0]        ppu_wdata;
  logic [7:0]        ppu_rdata;
  logic              ppu_ack;

  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;
  logic              mem_err;

  // Arbiter view.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  ppu_req, ppu_we, ppu_addr, ppu_wdata,
    output ppu_rdata, ppu_ack,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_err,
    input  mem_rdata, mem_ack
  );

  // Requesters and memory controller view.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output ppu_req, ppu_we, ppu_addr, ppu_wdata,
    input  ppu_rdata, ppu_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_err,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/nes_mem_timeout.sv
// 6-bit acknowledge watchdog: clears, counts, flags when the count hits TIMEOUT.
module nes_mem_timeout #(
  parameter int unsigned TIMEOUT = 63
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [5:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + 6'd1;
    end
  end

  assign expired = (cnt_q == 6'(TIMEOUT));

endmodule

// File: rtl/nes_mem_arbiter.sv
// Serialises PRG (CPU) and CHR (PPU) accesses onto one cartridge memory port;
// PPU has priority, bounded by PPU_RUN_MAX while the CPU is waiting.
module nes_mem_arbiter
  import nes_mem_pkg::*;
#(
  parameter int unsigned PPU_RUN_MAX = 4,
  parameter int unsigned TIMEOUT     = 63
) (
  input logic              clk,
  input logic              reset_n,
  nes_mem_arbiter_if.slave bus
);

  localparam logic [2:0] RUN_MAX = 3'(PPU_RUN_MAX);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [2:0]        ppu_run_q, ppu_run_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic [7:0]        ppu_rdata_q, ppu_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              ppu_ack_q, ppu_ack_d;
  logic              mem_err_q, mem_err_d;
  logic              grant_cpu;
  logic              expired;

  nes_mem_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_q != BUSY),
    .inc     (state_q == BUSY),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      ppu_run_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      ppu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      ppu_ack_q   <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ppu_run_q   <= ppu_run_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ppu_rdata_q <= ppu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      ppu_ack_q   <= ppu_ack_d;
      mem_err_q   <= mem_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ppu_run_d   = ppu_run_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ppu_rdata_d = ppu_rdata_q;
    cpu_ack_d   = 1'b0;
    ppu_ack_d   = 1'b0;
    mem_err_d   = 1'b0;
    grant_cpu   = bus.cpu_req && (!bus.ppu_req || (ppu_run_q == RUN_MAX));

    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req || bus.ppu_req) begin
          state_d   = BUSY;
          mem_req_d = 1'b1;
          if (grant_cpu) begin
            owner_d     = OWN_CPU;
            mem_we_d    = bus.cpu_we;
            mem_addr_d  = bus.cpu_addr;
            mem_wdata_d = bus.cpu_wdata;
            ppu_run_d   = '0;
          end else begin
            owner_d     = OWN_PPU;
            mem_we_d    = bus.ppu_we;
            mem_addr_d  = bus.ppu_addr;
            mem_wdata_d = bus.ppu_wdata;
            // The run only grows while the CPU is actually being held off.
            if (!bus.cpu_req) begin
              ppu_run_d = '0;
            end else if (ppu_run_q != RUN_MAX) begin
              ppu_run_d = ppu_run_q + 3'd1;
            end
          end
        end
      end

      BUSY: begin
        // A real acknowledge beats a watchdog expiry in the same cycle.
        if (bus.mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          if (owner_q == OWN_CPU) begin
            cpu_ack_d = 1'b1;
            if (!mem_we_q) cpu_rdata_d = bus.mem_rdata;
          end else begin
            ppu_ack_d = 1'b1;
            if (!mem_we_q) ppu_rdata_d = bus.mem_rdata;
          end
        end else if (expired) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          mem_err_d = 1'b1;
          if (owner_q == OWN_CPU) begin
            cpu_ack_d   = 1'b1;
            cpu_rdata_d = MEM_ERR_DATA;
          end else begin
            ppu_ack_d   = 1'b1;
            ppu_rdata_d = MEM_ERR_DATA;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_err   = mem_err_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.ppu_rdata = ppu_rdata_q;
  assign bus.ppu_ack   = ppu_ack_q;

endmodule

// File: tb/tb_nes_mem_arbiter.sv
// Scoreboard bench for nes_mem_arbiter: directed accesses against a latency-programmable controller.
module tb_nes_mem_arbiter;
  import nes_mem_pkg::*;

  typedef struct {
    logic [21:0] addr;
    logic        we;
    logic [7:0]  wdata;
    int          gap;
  } grant_t;

  typedef struct {
    logic        is_ppu;
    logic [7:0]  rdata;
    logic        err;
    int          lat;
  } resp_t;

  logic   clk = 1'b0;
  logic   reset_n;
  grant_t gq[$];
  resp_t  rq[$];
  grant_t g;
  resp_t  r;
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     ack_lat = 0;
  int     bcnt = 0;
  int     last_grant_cyc = 0;
  logic   prev_req = 1'b0;

  nes_mem_arbiter_if bus ();

  nes_mem_arbiter #(
    .PPU_RUN_MAX (4),
    .TIMEOUT     (63)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_grant(input logic [21:0] addr, input logic we, input logic [7:0] wdata, input int gap);
    grant_t e;
    e.addr = addr; e.we = we; e.wdata = wdata; e.gap = gap;
    gq.push_back(e);
  endtask

  task automatic exp_resp(input logic is_ppu, input logic [7:0] rdata, input logic err, input int lat);
    resp_t e;
    e.is_ppu = is_ppu; e.rdata = rdata; e.err = err; e.lat = lat;
    rq.push_back(e);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mem_req"},   32'(bus.mem_req),   32'h0);
    check({tag, "_mem_we"},    32'(bus.mem_we),    32'h0);
    check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'h0);
    check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'h0);
    check({tag, "_mem_err"},   32'(bus.mem_err),   32'h0);
    check({tag, "_cpu_ack"},   32'(bus.cpu_ack),   32'h0);
    check({tag, "_ppu_ack"},   32'(bus.ppu_ack),   32'h0);
    check({tag, "_cpu_rdata"}, 32'(bus.cpu_rdata), 32'h0);
    check({tag, "_ppu_rdata"}, 32'(bus.ppu_rdata), 32'h0);
  endtask

  // Raise a request right after an edge, hold it until the matching ack.
  task automatic access(input bit is_ppu, input logic we, input logic [21:0] addr, input logic [7:0] wdata);
    bit got = 1'b0;
    @(posedge clk); #1;
    if (is_ppu) begin
      bus.ppu_we = we; bus.ppu_addr = addr; bus.ppu_wdata = wdata; bus.ppu_req = 1'b1;
    end else begin
      bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_req = 1'b1;
    end
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      got = is_ppu ? bus.ppu_ack : bus.cpu_ack;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_ack_wait: got no ack expected ack within 300 cycles", is_ppu ? "ppu" : "cpu");
    end
    if (is_ppu) bus.ppu_req = 1'b0;
    else        bus.cpu_req = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Memory controller: acks ack_lat cycles into BUSY (-1 = never); data = addr[7:0] ^ 8'h4A.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h33;
    forever begin
      @(posedge clk); #1;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 8'h33;
      if (bus.mem_req) begin
        if (bcnt == ack_lat) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = bus.mem_addr[7:0] ^ 8'h4A;
        end
        bcnt++;
      end else begin
        bcnt = 0;
      end
    end
  end

  // Monitor: pops expected grants on mem_req rise and expected responses on each ack.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_req && !prev_req) begin
        if (gq.size() == 0) begin
          checks++; errors++;
          $display("FAIL grant_unexpected: got mem_req for %0h expected none", bus.mem_addr);
        end else begin
          g = gq.pop_front();
          check("grant_addr", 32'(bus.mem_addr), 32'(g.addr));
          check("grant_we", 32'(bus.mem_we), 32'(g.we));
          if (g.we) check("grant_wdata", 32'(bus.mem_wdata), 32'(g.wdata));
          if (g.gap >= 0) check("grant_gap", 32'(cyc - last_grant_cyc), 32'(g.gap));
        end
        last_grant_cyc = cyc;
      end
      prev_req = bus.mem_req;

      if (bus.cpu_ack || bus.ppu_ack) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL ack_unexpected: got cpu_ack=%0b ppu_ack=%0b expected none", bus.cpu_ack, bus.ppu_ack);
        end else begin
          r = rq.pop_front();
          check("ack_side", 32'({bus.cpu_ack, bus.ppu_ack}), r.is_ppu ? 32'h1 : 32'h2);
          check("rdata", 32'(r.is_ppu ? bus.ppu_rdata : bus.cpu_rdata), 32'(r.rdata));
          check("mem_err", 32'(bus.mem_err), 32'(r.err));
          check("ack_latency", 32'(cyc - last_grant_cyc), 32'(r.lat));
        end
      end else if (bus.mem_err) begin
        checks++; errors++;
        $display("FAIL err_stray: got mem_err=1 expected 0 without ack");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n       = 1'b0;
    bus.cpu_req   = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ppu_req   = 1'b0; bus.ppu_we = 1'b0; bus.ppu_addr = '0; bus.ppu_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // Single CPU read, controller acks 2 cycles into BUSY.
    ack_lat = 2;
    exp_grant(22'h3C0010, 1'b0, 8'h00, -1);
    exp_resp(1'b0, 8'h5A, 1'b0, 3);
    access(1'b0, 1'b0, 22'h3C0010, 8'h00);

    // CPU write must leave cpu_rdata holding the previous read.
    ack_lat = 0;
    exp_grant(22'h3C0020, 1'b1, 8'hC3, -1);
    exp_resp(1'b0, 8'h5A, 1'b0, 1);
    access(1'b0, 1'b1, 22'h3C0020, 8'hC3);

    // Simultaneous requests: PPU first, CPU 3 cycles later.
    exp_grant(22'h001234, 1'b0, 8'h00, -1);
    exp_grant(22'h2ABCDE, 1'b0, 8'h00, 3);
    exp_resp(1'b1, 8'h7E, 1'b0, 1);
    exp_resp(1'b0, 8'h94, 1'b0, 1);
    fork
      access(1'b1, 1'b0, 22'h001234, 8'h00);
      access(1'b0, 1'b0, 22'h2ABCDE, 8'h00);
    join

    // Continuous PPU traffic with CPU waiting: PPUx4, CPU, PPUx4, CPU.
    begin
      int pi = 0;
      int ci = 0;
      for (int k = 0; k < 10; k++) begin
        if (k == 4 || k == 9) begin
          exp_grant(22'(22'h3F0080 + ci), 1'b0, 8'h00, (k == 0) ? -1 : 3);
          exp_resp(1'b0, 8'(8'h80 + ci) ^ 8'h4A, 1'b0, 1);
          ci++;
        end else begin
          exp_grant(22'(22'h000100 + pi), 1'b0, 8'h00, (k == 0) ? -1 : 3);
          exp_resp(1'b1, 8'(pi) ^ 8'h4A, 1'b0, 1);
          pi++;
        end
      end
    end
    fork
      for (int i = 0; i < 8; i++) access(1'b1, 1'b0, 22'(22'h000100 + i), 8'h00);
      for (int j = 0; j < 2; j++) access(1'b0, 1'b0, 22'(22'h3F0080 + j), 8'h00);
    join

    // Controller never acks a CPU write: abort after 64 cycles with FF.
    ack_lat = -1;
    exp_grant(22'h155555, 1'b1, 8'h99, -1);
    exp_resp(1'b0, 8'hFF, 1'b1, 64);
    access(1'b0, 1'b1, 22'h155555, 8'h99);
    ack_lat = 0;
    exp_grant(22'h000077, 1'b0, 8'h00, -1);
    exp_resp(1'b0, 8'h3D, 1'b0, 1);
    access(1'b0, 1'b0, 22'h000077, 8'h00);

    // Ack lands on the timeout cycle: real data, no error.
    ack_lat = 63;
    exp_grant(22'h0ABC12, 1'b0, 8'h00, -1);
    exp_resp(1'b1, 8'h58, 1'b0, 64);
    access(1'b1, 1'b0, 22'h0ABC12, 8'h00);

    // Reset in the middle of a PPU read: no ack for the aborted access.
    ack_lat = -1;
    exp_grant(22'h2000F0, 1'b0, 8'h00, -1);
    @(posedge clk); #1;
    bus.ppu_we = 1'b0; bus.ppu_addr = 22'h2000F0; bus.ppu_wdata = 8'h00; bus.ppu_req = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check("busy_before_reset", 32'(bus.mem_req), 32'h1);
    reset_n     = 1'b0;
    bus.ppu_req = 1'b0;
    #1;
    check_reset_vals("async_rst");
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("held_rst");
    @(negedge clk);
    reset_n = 1'b1;
    ack_lat = 1;
    exp_grant(22'h2000F0, 1'b0, 8'h00, -1);
    exp_resp(1'b1, 8'hBA, 1'b0, 2);
    access(1'b1, 1'b0, 22'h2000F0, 8'h00);

    for (int n = 0; n < 50 && (rq.size() != 0 || gq.size() != 0); n++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("grants_left", 32'(gq.size()), 32'h0);
    check("resps_left", 32'(rq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
